cpa_arbiter: RTL and testbench
==============================

Name: cpa_arbiter

Overview:
Round-robin arbiter and sequencer that shares one external 64-bit carry-propagate adder between NUM_REQ requesters in the floating-point multiplier, for example mantissa final-add, exponent add and rounding increment. It accepts one operand pair per grant and registers it into the shared adder's inputs. It then captures the sum and carry-out and returns them tagged with the requester index over a valid/ready response channel. The adder stays a pure combinational instance outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 64, operand/sum width; must match the shared adder
ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, at most one bit high
req_a  input  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_cin  input  NUM_REQ  carry-in per requester
add_a  output  WIDTH  to shared adder input a (registered)
add_b  output  WIDTH  to shared adder input b (registered)
add_cin  output  1  to shared adder cin (registered)
add_sum  input  WIDTH  from shared adder sum
add_cout  input  1  from shared adder cout
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_sum  output  WIDTH  captured sum
rsp_cout  output  1  captured carry-out
rsp_id  output  ID_W  index of requester that owns the result

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset values: state=IDLE, add_a/add_b/add_cin=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states are IDLE, ADD and RESP.
- IDLE:
  - req_ready is combinational. It is one-hot for the first requester with valid=1, searching from (last_grant+1) mod NUM_REQ upward with wrap-around. It is all-zero when no requester is valid or the state is not IDLE.
  - On accept: latch that requester's a/b/cin into add_a/add_b/add_cin, latch its index into the id register, update last_grant, then go to ADD.
- ADD: the adder settles within one cycle. At the clock edge, capture add_sum into rsp_sum, add_cout into rsp_cout and the id into rsp_id, set rsp_valid=1, then go to RESP.
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. When rsp_ready=1, clear rsp_valid and go to IDLE. No new accept happens in RESP.
- Latency: accept at cycle T, rsp_valid high at T+2, earliest next accept at T+3. Peak throughput is one operation per 3 cycles.
- A requester must hold valid, a, b and cin stable until its req_ready bit is high. Dropping valid before grant is legal and discards the request.
- Simultaneous valids: exactly one grant per accept. A requester that was just granted becomes lowest priority.
- Width rule: sum = a + b + cin modulo 2^WIDTH, and cout is the bit-WIDTH carry. The block does no saturation or sign handling.
- add_* keep their last operands after an operation completes. They change only on accept.
- Asserting rst_n low in any state aborts the operation immediately. The in-flight result is lost, rsp_valid drops to 0 asynchronously, and no req_ready is high while rst_n=0.

Optional Feature:
CPA_ARB_STATS_EN:
- Defined: adds output busy_cycles [31:0]. It resets to 0 and increments every cycle the state is ADD or RESP, saturating at 0xFFFFFFFF. It also adds output grant_cnt [NUM_REQ*16-1:0], one 16-bit saturating accept counter per requester, reset to 0.
- Undefined: these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Single op: req 1 with a=0x0000_0000_0000_0005, b=0x3, cin=0 -> req_ready[1] in the same cycle; rsp_valid at +2 with sum=0x8, cout=0, id=1.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
- All 4 valid from reset and held -> grants in order 0,1,2,3; each rsp_id matches its request; spacing is 3 cycles with rsp_ready=1.
- Fairness: after a grant to 2, requests on 0 and 3 -> 3 granted before 0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready all 0; rsp_ready=1 -> IDLE the next cycle.
- Reset in ADD -> rsp_valid stays 0 and outputs are at reset values; with CPA_ARB_STATS_EN defined, busy_cycles=0 after reset and equals 2 per completed op when rsp_ready is tied high.

Source files
------------

// File: rtl/cpa_arbiter_if.sv
// cpa_arbiter_if: bundles the request, shared-adder and response channels of cpa_arbiter.
//
// Modports:
//   slave  - arbiter view: takes requests, drives the adder operands, takes the adder result,
//            drives the response channel.
//   master - environment view (requesters, adder instance, result consumer).
//
// Signals:
//   req_valid/req_ready     per-requester handshake (req_ready at most one-hot)
//   req_a/req_b             operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin                 per-requester carry-in
//   add_a/add_b/add_cin     registered operands to the shared combinational adder
//   add_sum/add_cout        shared adder result
//   rsp_valid/rsp_ready     result handshake
//   rsp_sum/rsp_cout/rsp_id captured result and owning requester index

interface cpa_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;

  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/cpa_arbiter.sv
// cpa_arbiter: round-robin arbiter/sequencer sharing one external combinational
// carry-propagate adder between NUM_REQ requesters.
//
// One operation takes three cycles: IDLE (grant + operand capture), ADD (adder settles, result
// captured), RESP (result held until consumed). The adder itself lives outside this block.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset; aborts any in-flight operation
//   bus          cpa_arbiter_if.slave: request, adder and response channels
//   busy_cycles  (CPA_ARB_STATS_EN only) saturating count of cycles spent in ADD or RESP
//   grant_cnt    (CPA_ARB_STATS_EN only) per-requester 16-bit saturating accept counters,
//                requester i at [i*16 +: 16]
//
// Optional feature: define CPA_ARB_STATS_EN to add the statistics counters and their ports.

module cpa_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpa_arbiter_if.slave          bus
`ifdef CPA_ARB_STATS_EN
  ,
  output logic [31:0]           busy_cycles,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic              accept;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              sel_cin;

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_found;

  // Gated by rst_n so no requester sees a grant while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a   = bus.req_a[i*WIDTH +: WIDTH];
        sel_b   = bus.req_b[i*WIDTH +: WIDTH];
        sel_cin = bus.req_cin[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          add_a_d      = sel_a;
          add_b_d      = sel_b;
          add_cin_d    = sel_cin;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = StAdd;
        end
      end
      StAdd: begin
        // Operands were registered last edge, so the adder output has settled.
        rsp_sum_d   = bus.add_sum;
        rsp_cout_d  = bus.add_cout;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef CPA_ARB_STATS_EN
  logic [31:0]              busy_q;
  logic [NUM_REQ-1:0][15:0] gcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      gcnt_q <= '0;
    end else begin
      if (state_q != StIdle && busy_q != '1) begin
        busy_q <= busy_q + 32'd1;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_idx == ID_W'(i) && gcnt_q[i] != '1) begin
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign busy_cycles = busy_q;
  assign grant_cnt   = gcnt_q;
`endif

endmodule

// File: tb/tb_cpa_arbiter.sv
// Bench for cpa_arbiter: a cycle-level model (round-robin pick, 3-cycle operation, arithmetic
// sum) is compared against the DUT on every falling edge, and directed scenarios add literal
// expectations for grant order, sums, back-pressure and reset.

module tb_cpa_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpa_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  // The shared external adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                       + {{W{1'b0}}, bus.add_cin};

`ifdef CPA_ARB_STATS_EN
  logic [31:0]     busy_cycles;
  logic [N*16-1:0] grant_cnt;
`endif

  cpa_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef CPA_ARB_STATS_EN
    ,
    .busy_cycles (busy_cycles),
    .grant_cnt   (grant_cnt)
`endif
  );

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_last;
  bit          m_pending;    // accepted, result arrives next cycle
  bit          m_rsp_valid;
  int          m_gid;
  logic [W-1:0] m_add_a, m_add_b;
  logic         m_add_cin;
  logic [W-1:0] m_sum;
  logic         m_cout;
  int           m_id;
  logic [31:0]  m_busy;
  int           m_gcnt[N];

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int c;
    for (int k = 1; k <= int'(N); k++) begin
      c = (last + k) % int'(N);
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_pending = 0; m_rsp_valid = 0; m_gid = 0;
    m_add_a = '0; m_add_b = '0; m_add_cin = 1'b0;
    m_sum = '0; m_cout = 1'b0; m_id = 0; m_busy = '0;
    for (int i = 0; i < int'(N); i++) m_gcnt[i] = 0;
  endtask

  // Advances the model across the coming rising edge using the inputs now present.
  task automatic model_step();
    int g;
    logic [W:0] full;
    if (m_pending || m_rsp_valid) begin
      if (m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
    end
    if (m_rsp_valid) begin
      if (bus.rsp_ready) m_rsp_valid = 0;
    end else if (m_pending) begin
      full = {1'b0, m_add_a} + {1'b0, m_add_b} + {{W{1'b0}}, m_add_cin};
      m_sum = full[W-1:0];
      m_cout = full[W];
      m_id = m_gid;
      m_pending = 0;
      m_rsp_valid = 1;
    end else begin
      g = rr_pick(bus.req_valid, m_last);
      if (g >= 0) begin
        m_pending = 1;
        m_last = g;
        m_gid = g;
        m_add_a = bus.req_a[g*W +: W];
        m_add_b = bus.req_b[g*W +: W];
        m_add_cin = bus.req_cin[g];
        if (m_gcnt[g] < 16'hFFFF) m_gcnt[g]++;
      end
    end
  endtask

  initial begin
    logic [N-1:0] exp_ready;
    int g;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      exp_ready = '0;
      if (rst_n && !m_pending && !m_rsp_valid) begin
        g = rr_pick(bus.req_valid, m_last);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("m_req_ready", {{(W+1-N){1'b0}}, bus.req_ready}, {{(W+1-N){1'b0}}, exp_ready});
      chk("m_add_a", {1'b0, bus.add_a}, {1'b0, m_add_a});
      chk("m_add_b", {1'b0, bus.add_b}, {1'b0, m_add_b});
      chk("m_add_cin", {{W{1'b0}}, bus.add_cin}, {{W{1'b0}}, m_add_cin});
      chk("m_rsp_valid", {{W{1'b0}}, bus.rsp_valid}, {{W{1'b0}}, m_rsp_valid});
      chk("m_rsp_sum", {1'b0, bus.rsp_sum}, {1'b0, m_sum});
      chk("m_rsp_cout", {{W{1'b0}}, bus.rsp_cout}, {{W{1'b0}}, m_cout});
      chk("m_rsp_id", {{(W+1-IW){1'b0}}, bus.rsp_id}, (W+1)'(m_id));
`ifdef CPA_ARB_STATS_EN
      chk("m_busy", {{(W-31){1'b0}}, busy_cycles}, {{(W-31){1'b0}}, m_busy});
      for (int i = 0; i < int'(N); i++)
        chk("m_grant_cnt", {{(W-15){1'b0}}, grant_cnt[i*16 +: 16]}, (W+1)'(m_gcnt[i]));
`endif
      if (rst_n) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i] = c;
  endtask

  // Waits (bounded) for a grant; called at posedge+1, returns at the sampling negedge.
  task automatic wait_grant(output logic [N-1:0] gnt);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    gnt = bus.req_ready;
    if (gnt == '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_timeout: got no grant within 10 cycles, required a grant");
    end
  endtask

  // Lone request on requester i, rsp_ready held high. Entered and left at posedge+1 in IDLE.
  task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [N-1:0] exp_rdy,
                       input logic [W-1:0] exp_sum, input logic exp_cout);
    set_req(i, a, b, c);
    @(negedge clk);
    chk("op_ready_same_cycle", (W+1)'(bus.req_ready), (W+1)'(exp_rdy));
    step();
    bus.req_valid[i] = 1'b0;
    @(negedge clk);
    chk("op_no_rsp_in_add", (W+1)'(bus.rsp_valid), (W+1)'(0));
    step();
    @(negedge clk);
    chk("op_rsp_valid_t2", (W+1)'(bus.rsp_valid), (W+1)'(1));
    chk("op_rsp_sum", {1'b0, bus.rsp_sum}, {1'b0, exp_sum});
    chk("op_rsp_cout", (W+1)'(bus.rsp_cout), (W+1)'(exp_cout));
    chk("op_rsp_id", (W+1)'(bus.rsp_id), (W+1)'(i));
    chk("op_add_a_held", {1'b0, bus.add_a}, {1'b0, a});
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gnt;
    logic [N-1:0] exp_order [4];
    int prev_cyc;
    int gi;
    logic [W-1:0] held_sum;

    // Reset with every requester valid: no grant may show while rst_n is low.
    rst_n = 1'b0;
    clear_reqs();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_zero", (W+1)'(bus.req_ready), (W+1)'(0));
    chk("rst_rsp_valid", (W+1)'(bus.rsp_valid), (W+1)'(0));
    chk("rst_add_a", {1'b0, bus.add_a}, (W+1)'(0));
    chk("rst_rsp_id", (W+1)'(bus.rsp_id), (W+1)'(0));
    step();
    clear_reqs();
    rst_n = 1'b1;
    step();

    // Single op and full carry ripple.
    do_op(1, 64'h5, 64'h3, 1'b0, 4'b0010, 64'h8, 1'b0);
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'b0001, 64'h0, 1'b1);
`ifdef CPA_ARB_STATS_EN
    chk("busy_two_per_op", (W+1)'(busy_cycles), (W+1)'(4));
`endif

    // All four valid straight out of reset: grants 0,1,2,3, three cycles apart.
    do_reset();
`ifdef CPA_ARB_STATS_EN
    chk("busy_after_reset", (W+1)'(busy_cycles), (W+1)'(0));
`endif
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;
    for (int i = 0; i < 4; i++)
      set_req(i, 64'(i * 100 + 1), 64'h7, 1'(i & 1));
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(gnt);
      chk("rr_order", (W+1)'(gnt), (W+1)'(exp_order[k]));
      if (k > 0) chk("rr_spacing", (W+1)'(cyc - prev_cyc), (W+1)'(3));
      prev_cyc = cyc;
      gi = 0;
      for (int j = 0; j < 4; j++) if (gnt[j]) gi = j;
      step();
      bus.req_valid[gi] = 1'b0;
    end
    repeat (3) step();

    // Fairness: after a grant to 2, requester 3 wins over 0.
    do_op(2, 64'h10, 64'h20, 1'b0, 4'b0100, 64'h30, 1'b0);
    set_req(0, 64'h1, 64'h1, 1'b0);
    set_req(3, 64'h2, 64'h2, 1'b1);
    wait_grant(gnt);
    chk("fair_first_3", (W+1)'(gnt), (W+1)'(4'b1000));
    step();
    bus.req_valid[3] = 1'b0;
    wait_grant(gnt);
    chk("fair_then_0", (W+1)'(gnt), (W+1)'(4'b0001));
    step();
    bus.req_valid[0] = 1'b0;
    repeat (3) step();

    // Back-pressure: result held five cycles, no grants meanwhile.
    bus.rsp_ready = 1'b0;
    set_req(1, 64'd10, 64'd20, 1'b0);
    wait_grant(gnt);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    set_req(0, 64'h55, 64'h1, 1'b0);
    held_sum = 64'd30;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", (W+1)'(bus.rsp_valid), (W+1)'(1));
      chk("bp_rsp_sum", {1'b0, bus.rsp_sum}, {1'b0, held_sum});
      chk("bp_rsp_id", (W+1)'(bus.rsp_id), (W+1)'(1));
      chk("bp_no_ready", (W+1)'(bus.req_ready), (W+1)'(0));
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_idle_next", (W+1)'(bus.req_ready), (W+1)'(4'b0001));
    chk("bp_rsp_cleared", (W+1)'(bus.rsp_valid), (W+1)'(0));
    step();
    bus.req_valid[0] = 1'b0;
    repeat (3) step();

    // Reset during ADD aborts the operation.
    set_req(2, 64'h5, 64'h6, 1'b0);
    step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstadd_rsp_valid", (W+1)'(bus.rsp_valid), (W+1)'(0));
    chk("rstadd_add_a", {1'b0, bus.add_a}, (W+1)'(0));
    chk("rstadd_req_ready", (W+1)'(bus.req_ready), (W+1)'(0));
    @(negedge clk);
    chk("rstadd_rsp_sum", {1'b0, bus.rsp_sum}, (W+1)'(0));
    clear_reqs();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstadd_stays_idle", (W+1)'(bus.rsp_valid), (W+1)'(0));
    end
`ifdef CPA_ARB_STATS_EN
    chk("rstadd_busy_zero", (W+1)'(busy_cycles), (W+1)'(0));
`endif
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
